// File: rtl/alut_mem_arbiter_pkg.sv
// Shared types and constants for the ALUT memory arbiter: owner tags,
// memory geometry and the default age-starvation threshold.
package alut_arb_pkg;

    localparam int ARB_ADDR_W     = 8;
    localparam int ARB_DATA_W     = 83;
    localparam int ARB_STARVE_MAX = 16;
    localparam int ARB_STARVE_W   = 5;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_ADD  = 2'b01,
        OWN_AGE  = 2'b10,
        OWN_APB  = 2'b11
    } owner_e;

    // Owner tag to one-hot requester vector, ordered {apb, age, add}.
    function automatic logic [2:0] owner_onehot(input owner_e own);
        logic [2:0] oh;
        case (own)
            OWN_ADD: oh = 3'b001;
            OWN_AGE: oh = 3'b010;
            OWN_APB: oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/alut_mem_arbiter_if.sv
// Requester-side bus of the ALUT memory arbiter: request/grant handshakes
// for the three requesters plus the shared read return.
interface alut_mem_arbiter_if
    import alut_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
);
    logic              add_req;
    logic              add_we;
    logic [ADDR_W-1:0] add_addr;
    logic [DATA_W-1:0] add_wdata;
    logic              add_gnt;
    logic              add_rvalid;

    logic              age_req;
    logic              age_we;
    logic [ADDR_W-1:0] age_addr;
    logic [DATA_W-1:0] age_wdata;
    logic              age_lock;
    logic              age_gnt;
    logic              age_rvalid;

    logic              apb_req;
    logic              apb_we;
    logic [ADDR_W-1:0] apb_addr;
    logic [DATA_W-1:0] apb_wdata;
    logic              apb_gnt;
    logic              apb_rvalid;

    logic [DATA_W-1:0] rd_data;

    modport slave (
        input  add_req, add_we, add_addr, add_wdata,
        input  age_req, age_we, age_addr, age_wdata, age_lock,
        input  apb_req, apb_we, apb_addr, apb_wdata,
        output add_gnt, age_gnt, apb_gnt,
        output add_rvalid, age_rvalid, apb_rvalid,
        output rd_data
    );

    modport master (
        output add_req, add_we, add_addr, add_wdata,
        output age_req, age_we, age_addr, age_wdata, age_lock,
        output apb_req, apb_we, apb_addr, apb_wdata,
        input  add_gnt, age_gnt, apb_gnt,
        input  add_rvalid, age_rvalid, apb_rvalid,
        input  rd_data
    );

endinterface

// File: rtl/alut_mem_arbiter_pick.sv
// Combinational priority picker: locked or starved age first, then
// address checker, age checker, APB host.
module alut_arb_pick
    import alut_arb_pkg::*;
(
    input  logic       add_req,
    input  logic       age_req,
    input  logic       apb_req,
    input  logic       age_lock,
    input  logic       starved,
    output logic [2:0] gnt_onehot,
    output owner_e     owner
);

    // Resolve the single winner for this cycle.
    always_comb begin
        owner = OWN_NONE;
        if (age_req && (age_lock || starved)) begin
            owner = OWN_AGE;
        end else if (add_req) begin
            owner = OWN_ADD;
        end else if (age_req) begin
            owner = OWN_AGE;
        end else if (apb_req) begin
            owner = OWN_APB;
        end else begin
            owner = OWN_NONE;
        end
    end

    assign gnt_onehot = owner_onehot(owner);

endmodule

// File: rtl/alut_mem_arbiter.sv
// Arbitrates the single-port ALUT memory between address checker, age checker
// and APB host; registered command stage and two-cycle tagged read return.
module alut_mem_arbiter
    import alut_arb_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int STARVE_MAX = ARB_STARVE_MAX
) (
    input  logic                    pclk,
    input  logic                    p_reset,
    alut_mem_arbiter_if.slave       req_if,
    output logic                    mem_cs,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic [ARB_STARVE_W-1:0] starve_cnt,
    output logic                    arb_busy
);

    logic [2:0]              pick_gnt_s;
    owner_e                  pick_own_s;
    logic [2:0]              gnt_s;
    logic                    starved_s;
    logic                    sel_we_s;
    logic [ADDR_W-1:0]       sel_addr_s;
    logic [DATA_W-1:0]       sel_wdata_s;

    logic                    mem_cs_r;
    logic                    mem_we_r;
    logic [ADDR_W-1:0]       mem_addr_r;
    logic [DATA_W-1:0]       mem_wdata_r;
    owner_e                  cmd_tag_r;
    logic [2:0]              rvalid_r;
    logic [ARB_STARVE_W-1:0] starve_cnt_r;

    assign starved_s = (starve_cnt_r == ARB_STARVE_W'(STARVE_MAX));

    alut_arb_pick u_pick (
        .add_req    (req_if.add_req),
        .age_req    (req_if.age_req),
        .apb_req    (req_if.apb_req),
        .age_lock   (req_if.age_lock),
        .starved    (starved_s),
        .gnt_onehot (pick_gnt_s),
        .owner      (pick_own_s)
    );

    // Grants are combinational but must stay low while reset is asserted.
    assign gnt_s = p_reset ? 3'b000 : pick_gnt_s;

    assign req_if.add_gnt = gnt_s[0];
    assign req_if.age_gnt = gnt_s[1];
    assign req_if.apb_gnt = gnt_s[2];

    // Route the winning requester's command fields toward the command stage.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = {ADDR_W{1'b0}};
        sel_wdata_s = {DATA_W{1'b0}};
        case (pick_own_s)
            OWN_ADD: begin
                sel_we_s    = req_if.add_we;
                sel_addr_s  = req_if.add_addr;
                sel_wdata_s = req_if.add_wdata;
            end
            OWN_AGE: begin
                sel_we_s    = req_if.age_we;
                sel_addr_s  = req_if.age_addr;
                sel_wdata_s = req_if.age_wdata;
            end
            OWN_APB: begin
                sel_we_s    = req_if.apb_we;
                sel_addr_s  = req_if.apb_addr;
                sel_wdata_s = req_if.apb_wdata;
            end
            default: begin
                sel_we_s    = 1'b0;
                sel_addr_s  = {ADDR_W{1'b0}};
                sel_wdata_s = {DATA_W{1'b0}};
            end
        endcase
    end

    // Command stage; address and data hold when idle, only reads carry a tag.
    always_ff @(posedge pclk or posedge p_reset) begin
        if (p_reset) begin
            mem_cs_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            cmd_tag_r   <= OWN_NONE;
        end else if (gnt_s != 3'b000) begin
            mem_cs_r    <= 1'b1;
            mem_we_r    <= sel_we_s;
            mem_addr_r  <= sel_addr_s;
            mem_wdata_r <= sel_wdata_s;
            cmd_tag_r   <= sel_we_s ? OWN_NONE : pick_own_s;
        end else begin
            mem_cs_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            cmd_tag_r   <= OWN_NONE;
        end
    end

    // Read tag stage: the tag lines up with mem_rdata one cycle after mem_cs.
    always_ff @(posedge pclk or posedge p_reset) begin
        if (p_reset) begin
            rvalid_r <= 3'b000;
        end else begin
            rvalid_r <= owner_onehot(cmd_tag_r);
        end
    end

    // Age starvation counter, saturating; cleared on grant or dropped request.
    always_ff @(posedge pclk or posedge p_reset) begin
        if (p_reset) begin
            starve_cnt_r <= {ARB_STARVE_W{1'b0}};
        end else if (req_if.age_req && !gnt_s[1]) begin
            if (starved_s) begin
                starve_cnt_r <= starve_cnt_r;
            end else begin
                starve_cnt_r <= starve_cnt_r + {{(ARB_STARVE_W-1){1'b0}}, 1'b1};
            end
        end else begin
            starve_cnt_r <= {ARB_STARVE_W{1'b0}};
        end
    end

    assign mem_cs     = mem_cs_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign starve_cnt = starve_cnt_r;
    assign arb_busy   = mem_cs_r | (|rvalid_r);

    assign req_if.add_rvalid = rvalid_r[0];
    assign req_if.age_rvalid = rvalid_r[1];
    assign req_if.apb_rvalid = rvalid_r[2];
    // The memory macro's output is already registered; gate it so idle reads as zero.
    assign req_if.rd_data    = (|rvalid_r) ? mem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_alut_mem_arbiter.sv
// Self-checking bench for alut_mem_arbiter: directed scenarios plus random
// traffic against a transaction-level reference model and memory array.
module tb_alut_mem_arbiter;
    import alut_arb_pkg::*;

    localparam int AW = 8;
    localparam int DW = 83;

    logic          pclk = 1'b0;
    logic          p_reset;
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [4:0]    starve_cnt;
    logic          arb_busy;

    alut_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    alut_mem_arbiter dut (
        .pclk       (pclk),
        .p_reset    (p_reset),
        .req_if     (bus),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .starve_cnt (starve_cnt),
        .arb_busy   (arb_busy)
    );

    always #5 pclk = ~pclk;

    // Write-first single-port memory macro, one cycle read latency.
    logic [DW-1:0] mem_array [256] = '{default: '0};
    always @(posedge pclk) begin
        if (mem_cs) begin
            if (mem_we) begin
                mem_array[mem_addr] <= mem_wdata;
                mem_rdata           <= mem_wdata;
            end else begin
                mem_rdata <= mem_array[mem_addr];
            end
        end
    end

    // Reference model: transactions in grant order, data from a shadow table.
    typedef struct {
        int            due;
        logic [2:0]    rv;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          ret_q[$];
    logic [DW-1:0] ref_mem [256] = '{default: '0};
    int            cyc;
    int            m_starve;
    logic          e_cs, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [2:0]    obs_g;
    int            checks   = 0;
    int            failures = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    function automatic owner_e ref_pick();
        if (bus.age_req && (bus.age_lock || m_starve == 16)) return OWN_AGE;
        if (bus.add_req) return OWN_ADD;
        if (bus.age_req) return OWN_AGE;
        if (bus.apb_req) return OWN_APB;
        return OWN_NONE;
    endfunction

    task automatic clear_inputs();
        bus.add_req = 1'b0; bus.add_we = 1'b0; bus.add_addr = '0; bus.add_wdata = '0;
        bus.age_req = 1'b0; bus.age_we = 1'b0; bus.age_addr = '0; bus.age_wdata = '0;
        bus.age_lock = 1'b0;
        bus.apb_req = 1'b0; bus.apb_we = 1'b0; bus.apb_addr = '0; bus.apb_wdata = '0;
    endtask

    task automatic model_reset();
        ret_q.delete();
        e_cs = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
        m_starve = 0;
    endtask

    task automatic check_reset_vals();
        @(negedge pclk);
        chk("rst_gnt", {bus.apb_gnt, bus.age_gnt, bus.add_gnt}, 3'b000);
        chk("rst_mem_cs", mem_cs, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_rvalid", {bus.apb_rvalid, bus.age_rvalid, bus.add_rvalid}, 3'b000);
        chk("rst_rd_data", bus.rd_data, '0);
        chk("rst_starve", starve_cnt, 5'd0);
        chk("rst_busy", arb_busy, 1'b0);
    endtask

    // One clock: check everything against the model, then advance the model.
    task automatic step(output owner_e g);
        logic [2:0]    exp_g, exp_rv;
        logic [DW-1:0] exp_rd;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        ret_t          r;
        @(negedge pclk);
        g = ref_pick();
        exp_g = (g == OWN_ADD) ? 3'b001 : (g == OWN_AGE) ? 3'b010 : (g == OWN_APB) ? 3'b100 : 3'b000;
        obs_g = {bus.apb_gnt, bus.age_gnt, bus.add_gnt};
        chk("gnt", obs_g, exp_g);
        chk("mem_cs", mem_cs, e_cs);
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        exp_rv = 3'b000;
        exp_rd = '0;
        if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
            r = ret_q.pop_front();
            exp_rv = r.rv;
            exp_rd = r.data;
        end
        chk("rvalid", {bus.apb_rvalid, bus.age_rvalid, bus.add_rvalid}, exp_rv);
        if (exp_rv != 3'b000) chk("rd_data", bus.rd_data, exp_rd);
        chk("starve_cnt", starve_cnt, m_starve[4:0]);
        chk("arb_busy", arb_busy, e_cs | (exp_rv != 3'b000));
        @(posedge pclk);
        if (g != OWN_NONE) begin
            we = (g == OWN_ADD) ? bus.add_we    : (g == OWN_AGE) ? bus.age_we    : bus.apb_we;
            a  = (g == OWN_ADD) ? bus.add_addr  : (g == OWN_AGE) ? bus.age_addr  : bus.apb_addr;
            wd = (g == OWN_ADD) ? bus.add_wdata : (g == OWN_AGE) ? bus.age_wdata : bus.apb_wdata;
            e_cs = 1'b1; e_we = we; e_addr = a; e_wdata = wd;
            if (we) ref_mem[a] = wd;
            else ret_q.push_back('{due: cyc + 2, rv: exp_g, data: ref_mem[a]});
        end else begin
            e_cs = 1'b0; e_we = 1'b0;
        end
        if (bus.age_req && g != OWN_AGE) m_starve = (m_starve < 16) ? m_starve + 1 : 16;
        else m_starve = 0;
        cyc++;
        #1;
    endtask

    initial begin
        owner_e g;
        int first_age, add_hits;
        logic [2:0] order [3];
        bit pa, pg, pp;

        clear_inputs();
        model_reset();
        cyc = 0;
        p_reset = 1'b1;
        bus.add_req = 1'b1;
        repeat (2) @(posedge pclk);
        check_reset_vals();
        @(posedge pclk); #1;
        p_reset = 1'b0;
        clear_inputs();

        // Preload addr 0x10 through APB, then address-checker read of it.
        bus.apb_req = 1'b1; bus.apb_we = 1'b1; bus.apb_addr = 8'h10;
        bus.apb_wdata = 83'h4_0000_0000_00AB_CDEF;
        step(g);
        clear_inputs();
        bus.add_req = 1'b1; bus.add_we = 1'b0; bus.add_addr = 8'h10;
        step(g);
        clear_inputs();
        repeat (3) step(g);

        // Starvation: add held, age promoted after 16 denied cycles.
        first_age = -1;
        bus.age_req = 1'b1; bus.age_we = 1'b0; bus.age_addr = 8'h10;
        for (int i = 0; i < 20; i++) begin
            bus.add_req = 1'b1; bus.add_we = 1'b0; bus.add_addr = 8'(i);
            step(g);
            if (obs_g[1] && first_age < 0) begin
                first_age = i;
                bus.age_req = 1'b0;
            end
        end
        chk("starve_first_age_gnt", 32'(first_age), 32'd16);
        clear_inputs();
        repeat (3) step(g);

        // Locked sweep: 256 zero writes, add held but never granted.
        add_hits = 0;
        bus.age_lock = 1'b1; bus.age_req = 1'b1; bus.age_we = 1'b1; bus.age_wdata = '0;
        bus.add_req = 1'b1; bus.add_addr = 8'h10;
        for (int i = 0; i < 256; i++) begin
            bus.age_addr = 8'(i);
            step(g);
            if (obs_g[0]) add_hits++;
        end
        chk("lock_add_gnt_count", 32'(add_hits), 32'd0);
        bus.age_lock = 1'b0; bus.age_req = 1'b0;
        step(g);
        chk("lock_release_add_gnt", obs_g, 3'b001);
        clear_inputs();
        repeat (3) step(g);

        // Three simultaneous reads: served add, age, apb.
        bus.add_req = 1'b1; bus.add_addr = 8'h10;
        bus.age_req = 1'b1; bus.age_addr = 8'h11;
        bus.apb_req = 1'b1; bus.apb_addr = 8'h12;
        for (int i = 0; i < 3; i++) begin
            step(g);
            order[i] = obs_g;
            if (obs_g[0]) bus.add_req = 1'b0;
            if (obs_g[1]) bus.age_req = 1'b0;
            if (obs_g[2]) bus.apb_req = 1'b0;
        end
        chk("order0", order[0], 3'b001);
        chk("order1", order[1], 3'b010);
        chk("order2", order[2], 3'b100);
        clear_inputs();
        repeat (4) step(g);

        // APB write then immediate add read of the same address.
        bus.apb_req = 1'b1; bus.apb_we = 1'b1; bus.apb_addr = 8'h05; bus.apb_wdata = 83'h1;
        step(g);
        clear_inputs();
        bus.add_req = 1'b1; bus.add_addr = 8'h05;
        step(g);
        clear_inputs();
        repeat (3) step(g);

        // Reset one cycle after an age read grant kills the return.
        bus.age_req = 1'b1; bus.age_addr = 8'h05;
        step(g);
        clear_inputs();
        #2;
        p_reset = 1'b1;
        check_reset_vals();
        @(posedge pclk); #1;
        p_reset = 1'b0;
        model_reset();
        repeat (4) step(g);

        // Random traffic; requests held until granted.
        pa = 1'b0; pg = 1'b0; pp = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pa && $urandom_range(2, 0) == 0) begin
                pa = 1'b1; bus.add_req = 1'b1; bus.add_we = 1'($urandom_range(1, 0));
                bus.add_addr = 8'($urandom_range(15, 0)); bus.add_wdata = rnd_data();
            end
            if (!pg && $urandom_range(3, 0) == 0) begin
                pg = 1'b1; bus.age_req = 1'b1; bus.age_we = 1'($urandom_range(1, 0));
                bus.age_addr = 8'($urandom_range(15, 0)); bus.age_wdata = rnd_data();
                bus.age_lock = ($urandom_range(7, 0) == 0);
            end
            if (!pp && $urandom_range(3, 0) == 0) begin
                pp = 1'b1; bus.apb_req = 1'b1; bus.apb_we = 1'($urandom_range(1, 0));
                bus.apb_addr = 8'($urandom_range(15, 0)); bus.apb_wdata = rnd_data();
            end
            step(g);
            if (g == OWN_ADD) begin pa = 1'b0; bus.add_req = 1'b0; end
            if (g == OWN_AGE) begin pg = 1'b0; bus.age_req = 1'b0; bus.age_lock = 1'b0; end
            if (g == OWN_APB) begin pp = 1'b0; bus.apb_req = 1'b0; end
        end
        clear_inputs();
        repeat (4) step(g);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
